vec_mem_seq: RTL and testbench
==============================

VEC_MEM_SEQ -- requirements
Module: vec_mem_seq

Interface
REQ-001 SHALL have parameter LANES, default 16, meaning number of vector lanes, each 32 bits wide.
REQ-002 SHALL have port CLK  in  1  clock; all state changes on the rising edge.
REQ-003 SHALL have port RST  in  1  reset; asynchronous, active-high.
REQ-004 SHALL have port start_i  in  1  vector memory op present in the E stage this cycle.
REQ-005 SHALL have port is_store_i  in  1  1=store, 0=load; sampled with start_i.
REQ-006 SHALL have port base_addr_i  in  32  byte address of lane 0; sampled with start_i.
REQ-007 SHALL have port wdata_i  in  LANES x 32  store data per lane; sampled with start_i.
REQ-008 SHALL have port lane_mask_i  in  LANES  per-lane enable; sampled with start_i.
REQ-009 SHALL have port mem_req_o  out  1  memory request valid.
REQ-010 SHALL have port mem_we_o  out  1  request is a write.
REQ-011 SHALL have port mem_addr_o  out  32  request address.
REQ-012 SHALL have port mem_wdata_o  out  32  write data for the current lane.
REQ-013 SHALL have port mem_ack_i  in  1  memory accepted/completed the request this cycle.
REQ-014 SHALL have port mem_rdata_i  in  32  read data, valid when mem_ack_i=1.
REQ-015 SHALL have port rdata_o  out  LANES x 32  assembled load result.
REQ-016 SHALL have port lane_idx_o  out  4  lane currently being accessed.
REQ-017 SHALL have port stall_o  out  1  freeze the F/D/E pipeline registers.
REQ-018 SHALL have port done_o  out  1  single-cycle completion pulse.

Function
REQ-019 SHALL implement the states IDLE, REQ and DONE.
REQ-020 IDLE with start_i=1: SHALL latch is_store, base, wdata and mask, SHALL load lane counter 0, SHALL clear rdata_o to 0 if the op is a load, and SHALL go to REQ.
REQ-021 start_i SHALL be ignored in REQ and DONE.
REQ-022 REQ: SHALL drive mem_req_o=1, mem_we_o=latched is_store, mem_addr_o=base+4*lane (mod 2^32) and mem_wdata_o=wdata[lane].
REQ-023 REQ: mem_req_o, mem_addr_o, mem_we_o and mem_wdata_o SHALL be held stable until mem_ack_i=1.
REQ-024 REQ with mem_ack_i=1 on a load: SHALL write mem_rdata_i into rdata_o[lane] at the clock edge.
REQ-025 REQ with mem_ack_i=1: SHALL go to DONE if lane=LANES-1; otherwise SHALL increment lane and stay in REQ, giving one lane per acked cycle.
REQ-026 DONE: SHALL drive done_o=1 and stall_o=0, and SHALL go to IDLE on the next edge; rdata_o SHALL be valid in DONE.
REQ-027 stall_o SHALL equal (state==IDLE & start_i) | (state==REQ), combinationally, so the pipeline freezes in the start cycle.
REQ-028 mem_req_o, mem_we_o and done_o SHALL be 0 outside REQ and DONE respectively.
REQ-029 mem_ack_i outside REQ SHALL be ignored.
REQ-030 rdata_o SHALL hold its value until the next load start.
REQ-031 Latency with mem_ack_i tied high: start cycle + LANES REQ cycles + 1 DONE cycle.

Reset
REQ-032 RST=1 SHALL asynchronously force IDLE, lane=0, rdata_o=0 and all latched operands=0.
REQ-033 During reset, mem_req_o=0, mem_we_o=0, done_o=0, stall_o=0 and lane_idx_o=0 SHALL hold.
REQ-034 RST asserted mid-operation SHALL abort with no further requests; the partially written rdata_o SHALL be cleared.

Configuration
REQ-035 Macro VSEQ_MASK_SKIP_EN defined: lanes with mask bit 0 SHALL be skipped with no request issued.
REQ-036 With VSEQ_MASK_SKIP_EN defined, the lane counter SHALL advance to the next set bit, and REQ SHALL exit to DONE after the highest set bit is acked.
REQ-037 With VSEQ_MASK_SKIP_EN defined, an all-zero mask SHALL go IDLE->DONE directly, with stall_o=1 only in the start cycle.
REQ-038 With VSEQ_MASK_SKIP_EN defined, skipped load lanes SHALL read 0.
REQ-039 Macro VSEQ_MASK_SKIP_EN undefined: lane_mask_i SHALL be ignored and all LANES lanes SHALL always be accessed.

Verification
REQ-040 Load, base=0x100, ack tied 1, memory returns addr: 16 requests to addresses 0x100..0x13C; rdata_o[i]=0x100+4i; done_o one cycle after the last ack; stall_o high for 17 cycles.
REQ-041 Store, base=0x200, wdata[i]=i*0x11, ack every 3rd cycle: each address/data pair held stable until ack; 16 writes; mem_we_o=1 throughout.
REQ-042 start_i pulsed again during REQ: ignored; request count stays 16.
REQ-043 RST asserted after lane 5 is acked: next cycle mem_req_o=0, state IDLE, rdata_o=0; a fresh start runs from lane 0.
REQ-044 Base=0xFFFFFFF8 load: addresses wrap to 0xFFFFFFF8, 0xFFFFFFFC, 0x0, ... with no error.
REQ-045 VSEQ_MASK_SKIP_EN defined, mask=0x8001: exactly 2 requests (lanes 0 and 15); other rdata lanes=0. Mask=0x0000: done_o asserted in the cycle after start, with no requests.

Source files
------------

// File: rtl/vec_mem_seq.sv
// ============================================================================
//  Module      : vec_mem_seq
//  Description : Vector memory sequencer. Expands one vector load/store into
//                one 32-bit memory request per lane, stalls the F/D/E
//                pipeline while it runs, assembles load data per lane and
//                pulses done when finished.
//  Option      : define VSEQ_MASK_SKIP_EN to skip lanes whose mask bit is 0
//                (no request issued, load lane reads 0). When it is not
//                defined, the mask is ignored and every lane is accessed.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module vec_mem_seq #(
    parameter int LANES = 16
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    start_i,
    input  logic                    is_store_i,
    input  logic [31:0]             base_addr_i,
    input  logic [LANES-1:0][31:0]  wdata_i,
    input  logic [LANES-1:0]        lane_mask_i,
    output logic                    mem_req_o,
    output logic                    mem_we_o,
    output logic [31:0]             mem_addr_o,
    output logic [31:0]             mem_wdata_o,
    input  logic                    mem_ack_i,
    input  logic [31:0]             mem_rdata_i,
    output logic [LANES-1:0][31:0]  rdata_o,
    output logic [3:0]              lane_idx_o,
    output logic                    stall_o,
    output logic                    done_o
);

    localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                   state, state_n;
    logic [LANE_W-1:0]        lane, lane_n;
    logic                     is_store_q;
    logic [31:0]              base_q;
    logic [LANES-1:0][31:0]   wdata_q;
    logic                     stall_raw;

`ifdef VSEQ_MASK_SKIP_EN
    logic [LANES-1:0]         mask_q;
    logic                     first_found, next_found;
    logic [LANE_W-1:0]        first_lane, next_lane;

    // Lowest set bit of the incoming mask, and lowest latched set bit above the current lane
    always_comb begin
        first_found = 1'b0;
        first_lane  = '0;
        next_found  = 1'b0;
        next_lane   = '0;
        for (int i = LANES - 1; i >= 0; i--) begin
            if (lane_mask_i[i]) begin
                first_found = 1'b1;
                first_lane  = LANE_W'(i);
            end
            if (mask_q[i] && (i > int'(lane))) begin
                next_found = 1'b1;
                next_lane  = LANE_W'(i);
            end
        end
    end
`else
    logic unused_mask;
    assign unused_mask = ^lane_mask_i;
`endif

    // State register
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next-state, lane advance and per-state control outputs
    always_comb begin
        state_n   = state;
        lane_n    = lane;
        stall_raw = 1'b0;
        mem_req_o = 1'b0;
        mem_we_o  = 1'b0;
        done_o    = 1'b0;
        case (state)
            IDLE: begin
                if (start_i) begin
                    stall_raw = 1'b1;
`ifdef VSEQ_MASK_SKIP_EN
                    lane_n  = first_lane;
                    state_n = first_found ? REQ : DONE;
`else
                    lane_n  = '0;
                    state_n = REQ;
`endif
                end
            end
            REQ: begin
                stall_raw = 1'b1;
                mem_req_o = 1'b1;
                mem_we_o  = is_store_q;
                if (mem_ack_i) begin
`ifdef VSEQ_MASK_SKIP_EN
                    if (next_found) begin
                        lane_n = next_lane;
                    end else begin
                        state_n = DONE;
                    end
`else
                    if (lane == LANE_W'(LANES - 1)) begin
                        state_n = DONE;
                    end else begin
                        lane_n = lane + 1'b1;
                    end
`endif
                end
            end
            DONE: begin
                done_o  = 1'b1;
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // Operand latch, lane counter and load-result assembly
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            lane       <= '0;
            is_store_q <= 1'b0;
            base_q     <= '0;
            wdata_q    <= '0;
            rdata_o    <= '0;
`ifdef VSEQ_MASK_SKIP_EN
            mask_q     <= '0;
`endif
        end else begin
            lane <= lane_n;
            if (state == IDLE && start_i) begin
                is_store_q <= is_store_i;
                base_q     <= base_addr_i;
                wdata_q    <= wdata_i;
`ifdef VSEQ_MASK_SKIP_EN
                mask_q     <= lane_mask_i;
`endif
                if (!is_store_i) begin
                    rdata_o <= '0;
                end
            end
            if (state == REQ && mem_ack_i && !is_store_q) begin
                rdata_o[lane] <= mem_rdata_i;
            end
        end
    end

    // Request address wraps naturally modulo 2^32
    assign mem_addr_o  = base_q + (32'(lane) << 2);
    assign mem_wdata_o = wdata_q[lane];
    assign lane_idx_o  = 4'(lane);
    // The pipeline is never frozen while reset is held
    assign stall_o     = stall_raw & ~RST;

endmodule

`default_nettype wire

// File: tb/tb_vec_mem_seq.sv
// ============================================================================
//  Module      : tb_vec_mem_seq
//  Description : Bench for vec_mem_seq. A lane-queue model predicts every
//                cycle's outputs; directed scenarios add literal checks.
//                Mask-skip scenarios follow VSEQ_MASK_SKIP_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_vec_mem_seq;

    localparam int LANES = 16;

    logic                    CLK = 1'b0;
    logic                    RST;
    logic                    start_i;
    logic                    is_store_i;
    logic [31:0]             base_addr_i;
    logic [LANES-1:0][31:0]  wdata_i;
    logic [LANES-1:0]        lane_mask_i;
    logic                    mem_req_o;
    logic                    mem_we_o;
    logic [31:0]             mem_addr_o;
    logic [31:0]             mem_wdata_o;
    logic                    mem_ack_i;
    logic [31:0]             mem_rdata_i;
    logic [LANES-1:0][31:0]  rdata_o;
    logic [3:0]              lane_idx_o;
    logic                    stall_o;
    logic                    done_o;

    vec_mem_seq #(.LANES(LANES)) dut (
        .CLK         (CLK),
        .RST         (RST),
        .start_i     (start_i),
        .is_store_i  (is_store_i),
        .base_addr_i (base_addr_i),
        .wdata_i     (wdata_i),
        .lane_mask_i (lane_mask_i),
        .mem_req_o   (mem_req_o),
        .mem_we_o    (mem_we_o),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_ack_i   (mem_ack_i),
        .mem_rdata_i (mem_rdata_i),
        .rdata_o     (rdata_o),
        .lane_idx_o  (lane_idx_o),
        .stall_o     (stall_o),
        .done_o      (done_o)
    );

    always #5 CLK = ~CLK;

    // Memory returns the address as data while acking, garbage otherwise
    assign mem_rdata_i = mem_ack_i ? mem_addr_o : 32'hDEAD_BEEF;

    int vectors = 0;
    int errors  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        vectors++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, want, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int          q[$];              // lanes still to be requested, in order
    bit          m_store;
    bit          m_done;
    logic [31:0] m_base;
    logic [31:0] m_wdata [LANES];
    logic [31:0] m_rdata [LANES];

    int cyc = 0, start_cyc = 0, done_cyc = 0, last_ack_cyc = 0;
    int nreq = 0, nstall = 0;
    bit done_seen = 1'b0;

    // Compare process: check outputs mid-cycle, then advance the model past the coming edge
    always @(negedge CLK) begin
        cyc++;
        if (RST) begin
            q.delete();
            m_done  = 1'b0;
            m_store = 1'b0;
            m_base  = '0;
            for (int i = 0; i < LANES; i++) begin
                m_rdata[i] = '0;
                m_wdata[i] = '0;
            end
            chk("rst_req",   {31'd0, mem_req_o}, 32'd0);
            chk("rst_we",    {31'd0, mem_we_o},  32'd0);
            chk("rst_done",  {31'd0, done_o},    32'd0);
            chk("rst_stall", {31'd0, stall_o},   32'd0);
            chk("rst_lane",  {28'd0, lane_idx_o}, 32'd0);
            for (int i = 0; i < LANES; i++) chk("rst_rdata", rdata_o[i], 32'd0);
        end else begin
            bit idle;
            idle = (q.size() == 0) && !m_done;
            chk("req",  {31'd0, mem_req_o}, {31'd0, (q.size() != 0)});
            chk("done", {31'd0, done_o},    {31'd0, m_done});
            chk("stall", {31'd0, stall_o},  {31'd0, (q.size() != 0) || (idle && start_i)});
            if (q.size() != 0) begin
                chk("we",    {31'd0, mem_we_o}, {31'd0, m_store});
                chk("addr",  mem_addr_o, m_base + 32'(4 * q[0]));
                chk("wdata", mem_wdata_o, m_wdata[q[0]]);
                chk("lane",  {28'd0, lane_idx_o}, 32'(q[0]));
            end
            for (int i = 0; i < LANES; i++) chk("rdata", rdata_o[i], m_rdata[i]);

            if (stall_o) nstall++;
            if (done_o) begin
                done_seen = 1'b1;
                done_cyc  = cyc;
            end

            if (m_done) begin
                m_done = 1'b0;
            end else if (q.size() != 0) begin
                if (mem_ack_i) begin
                    nreq++;
                    last_ack_cyc = cyc;
                    if (!m_store) m_rdata[q[0]] = mem_rdata_i;
                    void'(q.pop_front());
                    if (q.size() == 0) m_done = 1'b1;
                end
            end else if (start_i) begin
                start_cyc = cyc;
                m_store   = is_store_i;
                m_base    = base_addr_i;
                for (int i = 0; i < LANES; i++) begin
                    m_wdata[i] = wdata_i[i];
                    if (!is_store_i) m_rdata[i] = '0;
`ifdef VSEQ_MASK_SKIP_EN
                    if (lane_mask_i[i]) q.push_back(i);
`else
                    q.push_back(i);
`endif
                end
                if (q.size() == 0) m_done = 1'b1;
            end
        end
    end

    // ---------------- stimulus ----------------
    int ack_mode = 0;   // 0: ack every cycle, 1: ack every third cycle
    int tcyc = 0;

    task automatic step();
        @(posedge CLK);
        #1;
        tcyc++;
        mem_ack_i = (ack_mode == 0) ? 1'b1 : ((tcyc % 3) == 0);
    endtask

    task automatic kick(input bit st, input logic [31:0] base, input logic [LANES-1:0] mask);
        nreq       = 0;
        nstall     = 0;
        done_seen  = 1'b0;
        is_store_i = st;
        base_addr_i = base;
        lane_mask_i = mask;
        start_i    = 1'b1;
        step();
        start_i    = 1'b0;
    endtask

    task automatic wait_done(input string nm);
        int n;
        n = 0;
        while (!done_seen && n < 200) begin
            step();
            n++;
        end
        if (!done_seen) begin
            vectors++;
            errors++;
            $display("FAIL %s_timeout: got no done expected done within 200 cycles", nm);
        end
    endtask

    initial begin
        RST         = 1'b1;
        start_i     = 1'b1;
        is_store_i  = 1'b0;
        base_addr_i = 32'h0;
        wdata_i     = '0;
        lane_mask_i = '1;
        mem_ack_i   = 1'b1;
        step();
        step();
        chk("rst_stall_lit", {31'd0, stall_o}, 32'd0);
        chk("rst_req_lit",   {31'd0, mem_req_o}, 32'd0);
        start_i = 1'b0;
        step();
        RST = 1'b0;
        step();

        // Load, base 0x100, ack always high
        ack_mode = 0;
        kick(1'b0, 32'h100, '1);
        wait_done("A");
        chk("A_reqs",     32'(nreq), 32'd16);
        chk("A_stall",    32'(nstall), 32'd17);
        chk("A_latency",  32'(done_cyc - start_cyc), 32'd17);
        chk("A_done_gap", 32'(done_cyc - last_ack_cyc), 32'd1);
        chk("A_rd0",  rdata_o[0],  32'h100);
        chk("A_rd7",  rdata_o[7],  32'h11C);
        chk("A_rd15", rdata_o[15], 32'h13C);
        step();

        // Store, base 0x200, slow ack, extra start pulses while busy
        ack_mode = 1;
        for (int i = 0; i < LANES; i++) wdata_i[i] = 32'(i * 32'h11);
        kick(1'b1, 32'h200, '1);
        step();
        start_i = 1'b1;
        base_addr_i = 32'h900;
        step();
        step();
        start_i = 1'b0;
        wait_done("B");
        chk("B_reqs", 32'(nreq), 32'd16);
        chk("B_rd_kept", rdata_o[3], 32'h10C);
        step();

        // Reset after lane 5 is acked, then a fresh load
        ack_mode = 0;
        kick(1'b0, 32'h300, '1);
        begin
            int n;
            n = 0;
            while (nreq < 6 && n < 100) begin
                step();
                n++;
            end
        end
        chk("C_acks", 32'(nreq), 32'd6);
        RST = 1'b1;
        #1;
        chk("C_req_off", {31'd0, mem_req_o}, 32'd0);
        chk("C_rd_clr",  rdata_o[4], 32'd0);
        chk("C_lane0",   {28'd0, lane_idx_o}, 32'd0);
        step();
        RST = 1'b0;
        step();
        kick(1'b0, 32'h100, '1);
        chk("C_fresh_addr", mem_addr_o, 32'h100);
        wait_done("C");
        chk("C_reqs", 32'(nreq), 32'd16);
        step();

        // Address wrap
        ack_mode = 1;
        kick(1'b0, 32'hFFFF_FFF8, '1);
        wait_done("D");
        chk("D_rd0",  rdata_o[0],  32'hFFFF_FFF8);
        chk("D_rd1",  rdata_o[1],  32'hFFFF_FFFC);
        chk("D_rd2",  rdata_o[2],  32'h0000_0000);
        chk("D_rd15", rdata_o[15], 32'h0000_0034);
        step();

        // Sparse mask
        ack_mode = 0;
        kick(1'b0, 32'h400, 16'h8001);
        wait_done("E");
`ifdef VSEQ_MASK_SKIP_EN
        chk("E_reqs",  32'(nreq), 32'd2);
        chk("E_rd0",   rdata_o[0],  32'h400);
        chk("E_rd1",   rdata_o[1],  32'h0);
        chk("E_rd15",  rdata_o[15], 32'h43C);
        step();
        kick(1'b0, 32'h500, 16'h0000);
        wait_done("F");
        chk("F_reqs",    32'(nreq), 32'd0);
        chk("F_latency", 32'(done_cyc - start_cyc), 32'd1);
        chk("F_stall",   32'(nstall), 32'd1);
`else
        chk("E_reqs",  32'(nreq), 32'd16);
        chk("E_rd1",   rdata_o[1],  32'h404);
        chk("E_rd15",  rdata_o[15], 32'h43C);
`endif
        step();
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

`default_nettype wire
